// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - fetch and program-load signal bundle for instr_mem_loader
interface instr_mem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_err;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_valid, instruction, fetch_err, load_ready, load_done, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_valid, instruction, fetch_err, load_ready, load_done, busy
  );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory with clear sweep, streaming program load and fetch port
module instr_mem_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int BYTE_ADDR = 1,
  parameter int READ_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_loader_if.slave  bus
);
  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              load_ready_q, load_ready_d;
  logic              load_done_q, load_done_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // One pointer serves both the clear sweep and the load stream; they never overlap.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_ready_d = load_ready_q;
    load_done_d  = 1'b0;
    busy_d       = busy_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
        if (ptr_q == LAST_PTR) begin
          state_d      = S_LOAD;
          ptr_d        = '0;
          load_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.load_valid && load_ready_q) begin
          mem_we    = 1'b1;
          mem_wdata = bus.load_data;
          ptr_d     = ptr_q + PTR_W'(1);
          if (bus.load_last || (ptr_q == LAST_PTR)) begin
            state_d      = S_RUN;
            ptr_d        = '0;
            load_ready_d = 1'b0;
            load_done_d  = 1'b1;
            busy_d       = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (bus.load_start) begin
          state_d      = S_LOAD;
          ptr_d        = '0;
          load_ready_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      default: begin
        state_d      = S_CLEAR;
        ptr_d        = '0;
        load_ready_d = 1'b0;
        busy_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      ptr_q        <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      busy_q       <= busy_d;
    end
  end

  // Storage has no reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.busy       = busy_q;

  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              out_of_range;
  logic              fire;
  logic [DATA_W-1:0] rd_instr;
  logic              rd_err;

  // Out-of-range wins over misaligned and forces a zero word.
  always_comb begin
    idx          = (BYTE_ADDR != 0) ? (bus.fetch_addr >> 2) : bus.fetch_addr;
    misaligned   = (BYTE_ADDR != 0) && (bus.fetch_addr[1:0] != 2'b00);
    out_of_range = (idx >= DEPTH_A);
    fire         = bus.fetch_req && (state_q == S_RUN);
    rd_instr     = '0;
    rd_err       = 1'b0;
    if (out_of_range) begin
      rd_err = 1'b1;
    end else begin
      rd_instr = mem[idx[PTR_W-1:0]];
      rd_err   = misaligned;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_lat0
      assign bus.fetch_valid = fire;
      assign bus.instruction = fire ? rd_instr : '0;
      assign bus.fetch_err   = fire && rd_err;
    end else begin : g_lat1
      logic              fetch_valid_q, fetch_valid_d;
      logic [DATA_W-1:0] instruction_q, instruction_d;
      logic              fetch_err_q, fetch_err_d;

      always_comb begin
        fetch_valid_d = fire;
        instruction_d = fire ? rd_instr : '0;
        fetch_err_d   = fire && rd_err;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          fetch_valid_q <= 1'b0;
          instruction_q <= '0;
          fetch_err_q   <= 1'b0;
        end else begin
          fetch_valid_q <= fetch_valid_d;
          instruction_q <= instruction_d;
          fetch_err_q   <= fetch_err_d;
        end
      end

      assign bus.fetch_valid = fetch_valid_q;
      assign bus.instruction = instruction_q;
      assign bus.fetch_err   = fetch_err_q;
    end
  endgenerate
endmodule
